// File: rtl/reg_dump_uart_tx.sv
// Register-file dump streamer: header, PC and R0..R(N-1) sent big-endian
// over an 8N1 UART line, using the CPU debug read port.
module reg_dump_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          NUM_REGS     = 32,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [4:0]  RegFile_Address,
  input  logic [31:0] RegOut,
  input  logic [31:0] PCOut,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int             BW       = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0]  BAUD_MAX = BW'(CLKS_PER_BIT - 1);
  localparam logic [4:0]     LAST     = 5'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR,
    S_PC0, S_PC1, S_PC2, S_PC3,
    S_ADDR, S_CAP,
    S_W0, S_W1, S_W2, S_W3,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_pc;
  logic [31:0]   r_word;
  logic [4:0]    r_idx;
  logic [7:0]    r_shift;
  logic [3:0]    r_bit;
  logic [BW-1:0] r_baud;
  logic          r_act;
  logic          r_tx;
  logic          w_load;
  logic [7:0]    w_byte;
  logic          w_end;

  assign w_end = r_act && (r_bit == 4'd9)
              && (r_baud == BAUD_MAX);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_byte = 8'h00;
    unique case (r_state)
      S_IDLE: if (start) begin
        w_next = S_HDR;
        w_load = 1'b1;
        w_byte = HEADER;
      end
      S_HDR: if (w_end) begin
        w_next = S_PC0;
        w_load = 1'b1;
        w_byte = r_pc[31:24];
      end
      S_PC0: if (w_end) begin
        w_next = S_PC1;
        w_load = 1'b1;
        w_byte = r_pc[23:16];
      end
      S_PC1: if (w_end) begin
        w_next = S_PC2;
        w_load = 1'b1;
        w_byte = r_pc[15:8];
      end
      S_PC2: if (w_end) begin
        w_next = S_PC3;
        w_load = 1'b1;
        w_byte = r_pc[7:0];
      end
      S_PC3: if (w_end) w_next = S_ADDR;
      S_ADDR: w_next = S_CAP;
      // First byte comes straight from RegOut as word is captured.
      S_CAP: begin
        w_next = S_W0;
        w_load = 1'b1;
        w_byte = RegOut[31:24];
      end
      S_W0: if (w_end) begin
        w_next = S_W1;
        w_load = 1'b1;
        w_byte = r_word[23:16];
      end
      S_W1: if (w_end) begin
        w_next = S_W2;
        w_load = 1'b1;
        w_byte = r_word[15:8];
      end
      S_W2: if (w_end) begin
        w_next = S_W3;
        w_load = 1'b1;
        w_byte = r_word[7:0];
      end
      S_W3: if (w_end) begin
        w_next = (r_idx == LAST) ? S_FIN : S_ADDR;
      end
      S_FIN: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc   <= '0;
      r_word <= '0;
      r_idx  <= '0;
    end else begin
      if (r_state == S_IDLE && start) r_pc <= PCOut;
      if (r_state == S_CAP) r_word <= RegOut;
      if (r_state == S_W3 && w_end) begin
        r_idx <= (r_idx == LAST) ? 5'd0 : r_idx + 5'd1;
      end
    end
  end

  // Bit index: 0 start, 1..8 data LSB first, 9 stop.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx    <= 1'b1;
      r_act   <= 1'b0;
      r_bit   <= '0;
      r_baud  <= '0;
      r_shift <= '0;
    end else if (w_load) begin
      r_act   <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= w_byte;
      r_bit   <= '0;
      r_baud  <= '0;
    end else if (r_act) begin
      if (r_baud == BAUD_MAX) begin
        r_baud <= '0;
        if (r_bit == 4'd9) begin
          r_act <= 1'b0;
        end else begin
          r_bit <= r_bit + 4'd1;
          if (r_bit == 4'd8) begin
            r_tx <= 1'b1;
          end else begin
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[7:1]};
          end
        end
      end else begin
        r_baud <= r_baud + BW'(1);
      end
    end
  end

  assign tx              = r_tx;
  assign RegFile_Address = r_idx;
  assign busy            = (r_state != S_IDLE)
                        && (r_state != S_FIN);
  assign done            = (r_state == S_FIN);

endmodule

// File: tb/tb_reg_dump_uart_tx.sv
// Bench for reg_dump_uart_tx: frames decoded by a UART model and
// compared against byte lists built from PC and register contents.
module tb_reg_dump_uart_tx;

  localparam int CPB = 4;
  localparam int NA  = 2;
  localparam int NB  = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        st_a, st_b;
  logic [4:0]  addr_a, addr_b;
  logic [31:0] ro_a, ro_b;
  logic [31:0] pc_a, pc_b;
  logic        tx_a, tx_b;
  logic        busy_a, busy_b;
  logic        done_a, done_b;
  logic [31:0] regs_a [NA];
  logic [31:0] regs_b [NB];

  always #5 clk = ~clk;

  assign ro_a = (addr_a < 5'(NA)) ? regs_a[addr_a[0]]
                                  : 32'hBAD0BAD0;
  assign ro_b = regs_b[addr_b];

  reg_dump_uart_tx #(
    .CLKS_PER_BIT(CPB), .NUM_REGS(NA), .HEADER(8'hA5)
  ) dut_a (
    .clock(clk), .reset(rst), .start(st_a),
    .RegFile_Address(addr_a), .RegOut(ro_a),
    .PCOut(pc_a), .tx(tx_a), .busy(busy_a),
    .done(done_a)
  );

  reg_dump_uart_tx #(
    .CLKS_PER_BIT(CPB), .NUM_REGS(NB), .HEADER(8'hA5)
  ) dut_b (
    .clock(clk), .reset(rst), .start(st_b),
    .RegFile_Address(addr_b), .RegOut(ro_b),
    .PCOut(pc_b), .tx(tx_b), .busy(busy_b),
    .done(done_b)
  );

  int         total = 0;
  int         bad   = 0;
  logic       q_tx[$];
  logic [4:0] q_addr[$];
  int         done_at;
  int         busy_gap;
  logic       busy_at_done;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Entered on the falling edge right after the accepting clock edge.
  task automatic capture(input int sel, input int limit,
                         input int hold);
    logic d, b, t;
    logic [4:0] a;
    q_tx.delete();
    q_addr.delete();
    done_at      = -1;
    busy_gap     = 0;
    busy_at_done = 1'b1;
    for (int n = 0; n <= limit; n++) begin
      if (n > 0) @(negedge clk);
      if (sel == 0 && hold > 0) st_a = (n < hold);
      d = sel ? done_b : done_a;
      b = sel ? busy_b : busy_a;
      t = sel ? tx_b   : tx_a;
      a = sel ? addr_b : addr_a;
      if (d === 1'b1) begin
        done_at      = n;
        busy_at_done = b;
        break;
      end
      if (b !== 1'b1) busy_gap++;
      q_tx.push_back(t);
      if (sel == 1) begin
        if (q_addr.size() == 0 || q_addr[$] !== a)
          q_addr.push_back(a);
      end
    end
  endtask

  task automatic check_frame(input int sel,
                             input logic [31:0] pcv,
                             input int nregs);
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    logic [7:0]  bv;
    logic [31:0] w;
    int          i, ix, serr;
    exp_q.push_back(8'hA5);
    for (int k = 3; k >= 0; k--) exp_q.push_back(pcv[8*k +: 8]);
    for (int r = 0; r < nregs; r++) begin
      w = sel ? regs_b[r] : regs_a[r];
      for (int k = 3; k >= 0; k--) exp_q.push_back(w[8*k +: 8]);
    end
    serr = 0;
    i = 0;
    while (i < q_tx.size()) begin
      if (q_tx[i] === 1'b0) begin
        for (int k = 0; k < 8; k++) begin
          ix = i + CPB/2 + CPB*(k+1);
          bv[k] = (ix < q_tx.size()) ? q_tx[ix] : 1'bx;
        end
        got_q.push_back(bv);
        ix = i + CPB/2 + 9*CPB;
        if (ix >= q_tx.size() || q_tx[ix] !== 1'b1) serr++;
        i = ix + 1;
      end else begin
        i++;
      end
    end
    chk("byte_count", got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk("frame_byte", {24'h0, got_q[k]}, {24'h0, exp_q[k]});
    chk("stop_bits", serr, 0);
    chk("done_cycle", done_at,
        (5 + 4*nregs)*10*CPB + 2*nregs);
    chk("busy_in_frame", busy_gap, 0);
    chk("busy_at_done", {31'h0, busy_at_done}, 0);
  endtask

  initial begin
    logic [31:0] pcv;
    int          act, aerr;
    rst  = 1'b1;
    st_a = 1'b0;
    st_b = 1'b0;
    pc_a = '0;
    pc_b = '0;
    for (int r = 0; r < NA; r++) regs_a[r] = '0;
    for (int r = 0; r < NB; r++) regs_b[r] = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx_a",   {31'h0, tx_a},   1);
    chk("rst_busy_a", {31'h0, busy_a}, 0);
    chk("rst_done_a", {31'h0, done_a}, 0);
    chk("rst_addr_a", {27'h0, addr_a}, 0);
    chk("rst_tx_b",   {31'h0, tx_b},   1);
    chk("rst_busy_b", {31'h0, busy_b}, 0);
    chk("rst_done_b", {31'h0, done_b}, 0);
    chk("rst_addr_b", {27'h0, addr_b}, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed frame; PC changes one cycle after start.
    regs_a[0] = 32'h0;
    regs_a[1] = 32'hDEADBEEF;
    pc_a = 32'h00400010;
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    pc_a = 32'hFFFFFFFF;
    chk("first_start_bit", {31'h0, tx_a}, 0);
    capture(0, 700, 0);
    check_frame(0, 32'h00400010, NA);

    // start in the done cycle is dropped, next cycle is taken.
    pcv = $urandom;
    pc_a = pcv;
    regs_a[0] = $urandom;
    regs_a[1] = $urandom;
    st_a = 1'b1;
    @(negedge clk);
    chk("fin_start_busy", {31'h0, busy_a}, 0);
    chk("fin_start_tx",   {31'h0, tx_a},   1);
    @(negedge clk);
    st_a = 1'b0;
    pc_a = ~pcv;
    capture(0, 700, 0);
    check_frame(0, pcv, NA);

    // start held high for 100 cycles: a single frame.
    @(negedge clk);
    pcv = $urandom;
    pc_a = pcv;
    regs_a[0] = $urandom;
    regs_a[1] = $urandom;
    st_a = 1'b1;
    @(negedge clk);
    capture(0, 700, 100);
    st_a = 1'b0;
    check_frame(0, pcv, NA);
    act = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0) act++;
    end
    chk("single_frame", act, 0);

    // Full 32-register sweep, R[i] = i*0x01010101.
    for (int r = 0; r < NB; r++) regs_b[r] = r * 32'h01010101;
    pcv = $urandom;
    pc_b = pcv;
    st_b = 1'b1;
    @(negedge clk);
    st_b = 1'b0;
    pc_b = $urandom;
    capture(1, 6000, 0);
    check_frame(1, pcv, NB);
    chk("addr_steps", q_addr.size(), NB);
    aerr = 0;
    for (int k = 0; k < q_addr.size(); k++)
      if (q_addr[k] !== 5'(k)) aerr++;
    chk("addr_monotonic", aerr, 0);
    chk("addr_after_done", {27'h0, addr_b}, 0);

    // Random register contents on the wide instance.
    @(negedge clk);
    for (int r = 0; r < NB; r++) regs_b[r] = $urandom;
    pcv = $urandom;
    pc_b = pcv;
    st_b = 1'b1;
    @(negedge clk);
    st_b = 1'b0;
    capture(1, 6000, 0);
    check_frame(1, pcv, NB);

    // Reset in the middle of the third byte.
    @(negedge clk);
    pc_a = $urandom;
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    repeat (95) @(negedge clk);
    chk("busy_before_rst", {31'h0, busy_a}, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_tx",   {31'h0, tx_a},   1);
    chk("midrst_busy", {31'h0, busy_a}, 0);
    chk("midrst_done", {31'h0, done_a}, 0);
    chk("midrst_addr", {27'h0, addr_a}, 0);
    act = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0)
        act++;
    end
    chk("quiet_after_rst", act, 0);

    // Recovery frame after the abandoned one.
    pcv = $urandom;
    pc_a = pcv;
    regs_a[0] = $urandom;
    regs_a[1] = $urandom;
    st_a = 1'b1;
    @(negedge clk);
    st_a = 1'b0;
    capture(0, 700, 0);
    check_frame(0, pcv, NA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
